// File: rtl/riscv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_pkg - shared writeback types (result width, register address, request)
// Revision: 1.0
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       value;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/riscv_wb_lq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_wb_lq - in-order load queue with per-entry live bit, kill-by-rd, pending mask
// Revision: 1.0
// ---------------------------------------------------------------------------
module riscv_wb_lq
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_req_t               push_req,
  input  logic                  pop,
  input  logic                  kill,
  input  logic [REG_ADDR_W-1:0] kill_rd,
  output wb_req_t               head_req,
  output logic                  head_live,
  output logic [$clog2(DEPTH):0] count,
  output logic [31:0]           pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t          mem [DEPTH];
  logic [DEPTH-1:0] live;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      live  <= '0;
    end else begin
      // Killed entries keep their slot so they still pop in order, just without a write.
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && live[i] && (mem[i].rd == kill_rd)) live[i] <= 1'b0;
      end
      if (pop) begin
        live[head] <= 1'b0;
        head       <= head + PW'(1);
      end
      if (push) begin
        live[tail] <= 1'b1;
        tail       <= tail + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_req;
  end

  assign head_req  = mem[head];
  assign head_live = live[head];

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i]) pending[mem[i].rd] = 1'b1;
    end
    pending[0] = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/riscv_wb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_wb_arbiter - merges ALU and load results into one registered regfile write
// Revision: 1.0
// ---------------------------------------------------------------------------
module riscv_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int LQ_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      alu_valid_i,
  input  logic [4:0]                alu_rd_i,
  input  logic [XLEN-1:0]           alu_value_i,
  input  logic                      lsu_valid_i,
  output logic                      lsu_ready_o,
  input  logic [4:0]                lsu_rd_i,
  input  logic [XLEN-1:0]           lsu_value_i,
  output logic                      wb_wr_o,
  output logic [4:0]                wb_rd_o,
  output logic [XLEN-1:0]           wb_value_o,
  output logic [31:0]               pending_o,
  output logic [$clog2(LQ_DEPTH):0] lq_count_o
);

  localparam int CW = $clog2(LQ_DEPTH) + 1;

  wb_req_t head_req;
  wb_req_t push_req;
  logic    head_live;
  logic    lq_empty;
  logic    alu_sel;
  logic    pop_sel;
  logic    cut_sel;
  logic    lsu_hs;
  logic    lsu_push;
  logic    same_rd;

  assign lq_empty    = (lq_count_o == '0);
  assign lsu_ready_o = !rst_i && (lq_count_o < CW'(LQ_DEPTH));
  assign lsu_hs      = lsu_valid_i && lsu_ready_o;

  assign alu_sel = alu_valid_i && (alu_rd_i != 5'd0);
  assign pop_sel = !alu_sel && !lq_empty;
  assign cut_sel = !alu_sel && lq_empty && lsu_hs && (lsu_rd_i != 5'd0);

  // A load arriving alongside an ALU result to the same rd is older, so it is already dead.
  assign same_rd  = alu_sel && (lsu_rd_i == alu_rd_i);
  assign lsu_push = lsu_hs && (lsu_rd_i != 5'd0) && !cut_sel && !same_rd;
  assign push_req = '{rd: lsu_rd_i, value: lsu_value_i};

  riscv_wb_lq #(
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (lsu_push),
    .push_req  (push_req),
    .pop       (pop_sel),
    .kill      (alu_sel),
    .kill_rd   (alu_rd_i),
    .head_req  (head_req),
    .head_live (head_live),
    .count     (lq_count_o),
    .pending   (pending_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_wr_o    <= 1'b0;
      wb_rd_o    <= '0;
      wb_value_o <= '0;
    end else begin
      wb_wr_o <= alu_sel || (pop_sel && head_live) || cut_sel;
      if (alu_sel) begin
        wb_rd_o    <= alu_rd_i;
        wb_value_o <= alu_value_i;
      end else if (pop_sel && head_live) begin
        wb_rd_o    <= head_req.rd;
        wb_value_o <= head_req.value;
      end else if (cut_sel) begin
        wb_rd_o    <= lsu_rd_i;
        wb_value_o <= lsu_value_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_wb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_riscv_wb_arbiter - directed and random stimulus against a queue-based reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_riscv_wb_arbiter;

  localparam int LQ_DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_value_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_value_i;
  logic        wb_wr_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_value_o;
  logic [31:0] pending_o;
  logic [1:0]  lq_count_o;

  riscv_wb_arbiter #(.XLEN(32), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .alu_valid_i (alu_valid_i),
    .alu_rd_i    (alu_rd_i),
    .alu_value_i (alu_value_i),
    .lsu_valid_i (lsu_valid_i),
    .lsu_ready_o (lsu_ready_o),
    .lsu_rd_i    (lsu_rd_i),
    .lsu_value_i (lsu_value_i),
    .wb_wr_o     (wb_wr_o),
    .wb_rd_o     (wb_rd_o),
    .wb_value_o  (wb_value_o),
    .pending_o   (pending_o),
    .lq_count_o  (lq_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] value;
    bit          live;
  } ent_t;

  ent_t        lq[$];
  logic        m_wr;
  logic [4:0]  m_rd;
  logic [31:0] m_val;
  logic        last_hs;
  logic [31:0] model_rf [32];
  logic [31:0] dut_rf   [32];
  int          n_cmp;
  int          n_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    for (int i = 0; i < lq.size(); i++)
      if (lq[i].live) p[lq[i].rd] = 1'b1;
    return p;
  endfunction

  task automatic push_load(input logic [4:0] rd, input logic [31:0] v);
    ent_t e;
    e.rd = rd; e.value = v; e.live = 1'b1;
    lq.push_back(e);
  endtask

  // One clock of stimulus; called off-edge, returns one time unit after the next rising edge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] aval,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] lval);
    logic m_ready;
    logic hs;
    ent_t e;
    alu_valid_i = av; alu_rd_i = ard; alu_value_i = aval;
    lsu_valid_i = lv; lsu_rd_i = lrd; lsu_value_i = lval;
    #1;
    m_ready = (lq.size() < LQ_DEPTH);
    check_eq("lsu_ready", lsu_ready_o, m_ready);
    check_eq("pending", pending_o, model_pending());
    check_eq("lq_count", lq_count_o, lq.size());
    hs = lv && m_ready;
    last_hs = hs;
    m_wr = 1'b0;
    if (av && ard != 0) begin
      m_wr = 1'b1; m_rd = ard; m_val = aval;
      for (int i = 0; i < lq.size(); i++)
        if (lq[i].rd == ard) lq[i].live = 1'b0;
      if (hs && lrd != 0 && lrd != ard) push_load(lrd, lval);
    end else if (lq.size() != 0) begin
      e = lq.pop_front();
      if (e.live) begin m_wr = 1'b1; m_rd = e.rd; m_val = e.value; end
      if (hs && lrd != 0) push_load(lrd, lval);
    end else if (hs && lrd != 0) begin
      m_wr = 1'b1; m_rd = lrd; m_val = lval;
    end
    if (m_wr) model_rf[m_rd] = m_val;
    @(posedge clk_i);
    #1;
    check_eq("wb_wr", wb_wr_o, m_wr);
    check_eq("wb_rd", wb_rd_o, m_rd);
    check_eq("wb_value", wb_value_o, m_val);
    if (wb_wr_o) dut_rf[wb_rd_o] = wb_value_o;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int k;
    n_cmp = 0; n_err = 0;
    m_wr = 1'b0; m_rd = '0; m_val = '0; last_hs = 1'b0;
    for (int i = 0; i < 32; i++) begin model_rf[i] = '0; dut_rf[i] = '0; end
    rst_i = 1'b1;
    alu_valid_i = 0; alu_rd_i = 0; alu_value_i = 0;
    lsu_valid_i = 1; lsu_rd_i = 5'd3; lsu_value_i = 0;

    // Reset state
    @(posedge clk_i); @(posedge clk_i); #1;
    check_eq("rst_wb_wr", wb_wr_o, 1'b0);
    check_eq("rst_ready", lsu_ready_o, 1'b0);
    check_eq("rst_pending", pending_o, 32'd0);
    lsu_valid_i = 0;
    rst_i = 1'b0;
    #1;
    check_eq("rel_ready", lsu_ready_o, 1'b1);
    check_eq("rel_count", lq_count_o, 2'd0);

    // Simple ALU write and x0 suppression
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    check_eq("t2_wr", wb_wr_o, 1'b1);
    check_eq("t2_value", wb_value_o, 32'hDEADBEEF);
    step(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0);
    check_eq("t2_x0_wr", wb_wr_o, 1'b0);

    // ALU wins, load queued then written
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    check_eq("t3_pending4", pending_o[4], 1'b1);
    idle();
    check_eq("t3_value", wb_value_o, 32'h22);
    check_eq("t3_pending", pending_o, 32'd0);

    // Backpressure while ALU streams, then in-order drain
    k = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 5'(c + 1), $urandom, k < 3, 5'(8 + k), 32'h100 + k);
      if (last_hs) k++;
    end
    check_eq("t4_accepts", k, 2);
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 5'd0, 32'd0, k < 3, 5'(8 + k), 32'h100 + k);
      if (last_hs) k++;
    end
    check_eq("t4_drain", lq_count_o, 2'd0);
    check_eq("t4_x10", dut_rf[10], 32'h102);

    // WAW kill of a queued load
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'hAA);
    step(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 32'd0);
    check_eq("t5_pending7", pending_o[7], 1'b0);
    idle();
    check_eq("t5_squash_wr", wb_wr_o, 1'b0);
    idle();
    check_eq("t5_x7", dut_rf[7], 32'h55);

    // Reset while draining
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC12);
    step(1'b1, 5'd2, 32'h2, 1'b1, 5'd13, 32'hC13);
    idle();
    #2 rst_i = 1'b1;
    #1;
    check_eq("t6_wr", wb_wr_o, 1'b0);
    check_eq("t6_rd", wb_rd_o, 5'd0);
    check_eq("t6_value", wb_value_o, 32'd0);
    check_eq("t6_pending", pending_o, 32'd0);
    check_eq("t6_count", lq_count_o, 2'd0);
    check_eq("t6_ready", lsu_ready_o, 1'b0);
    lq.delete();
    m_wr = 1'b0; m_rd = '0; m_val = '0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int c = 0; c < 4; c++) idle();

    // Randomized traffic with narrow rd range to force collisions
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    end
    for (int c = 0; c < 4; c++) idle();

    for (int i = 0; i < 32; i++) check_eq("regfile", dut_rf[i], model_rf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
